// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DEFAULT_XLEN : default datapath width (must match the register file)
//   REG_ADDR_W   : register index width
//   NUM_REGS     : architectural register count
//   wb_entry_t   : one pending writeback {rd, data} at the default width
package regfile_wb_pkg;
  localparam int DEFAULT_XLEN = 64;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [DEFAULT_XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO for long-latency writeback results.
//   clk, reset_n : clock, async active-low reset (empties the FIFO)
//   push, push_data : enqueue (ignored when full)
//   pop          : dequeue head (ignored when empty)
//   head         : current head entry (valid when !empty)
//   full, empty  : occupancy flags, derived from the entry count only
module wb_sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Sole owner of the register-file write port. Merges the ALU result stream
// (always accepted, priority) with buffered long-latency results into one
// registered write per cycle.
//   clk, reset_n           : clock, async active-low reset
//   alu_valid/rd/data      : ALU result, no backpressure
//   alu_stall              : buffer full, upstream must hold alu_valid low
//   lu_valid/ready/rd/data : long-latency result handshake into the buffer
//   issue_valid/rd         : long-latency op issued (scoreboard set)
//   busy_mask              : pending long-latency destinations, bit0 always 0
//   wb_reg_write/rd/data   : registered register-file write port
//   protocol_err           : sticky, alu_valid seen while alu_stall
// Optional feature: define REGFILE_WB_SCOREBOARD_EN to build the busy
// scoreboard; otherwise busy_mask is tied low and issue_* is ignored.
module regfile_writeback_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_stall,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  protocol_err
);
  // Local entry type so a non-default XLEN still packs correctly.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } entry_t;

  entry_t push_ent, head, sel;
  logic   full, empty, fifo_pop, accept;

  assign push_ent = '{rd: lu_rd, data: lu_data};
  assign lu_ready  = !full;
  assign alu_stall = full;
  // ALU always wins; the buffer only drains on ALU-idle cycles.
  assign fifo_pop  = !alu_valid && !empty;
  assign accept    = alu_valid || fifo_pop;

  wb_sync_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (lu_valid && lu_ready),
    .push_data (push_ent),
    .pop       (fifo_pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    sel = head;
    if (alu_valid) sel = '{rd: alu_rd, data: alu_data};
  end

  // rd==0 results are consumed but never raise reg_write; rd/data still
  // track the last consumed result, and hold across idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      protocol_err <= 1'b0;
    end else begin
      wb_reg_write <= accept && (sel.rd != '0);
      if (accept) begin
        wb_rd   <= sel.rd;
        wb_data <= sel.data;
      end
      if (alu_valid && full) protocol_err <= 1'b1;
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q, set_mask, clr_mask;

  assign set_mask = (issue_valid && issue_rd != '0) ? (NUM_REGS'(1) << issue_rd) : '0;
  assign clr_mask = fifo_pop ? (NUM_REGS'(1) << head.rd) : '0;

  // Set after clear so a same-cycle re-issue keeps the bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
  end

  assign busy_mask = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd};
  assign busy_mask    = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            alu_valid, lu_valid, issue_valid;
  logic [4:0]      alu_rd, lu_rd, issue_rd;
  logic [XLEN-1:0] alu_data, lu_data;
  logic            alu_stall, lu_ready, wb_reg_write, protocol_err;
  logic [31:0]     busy_mask;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_mask(busy_mask),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .protocol_err(protocol_err)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic test_reset;
    #1;
    total++; if (wb_reg_write !== 1'b0) $display("FAIL reset_wr got %b exp 0", wb_reg_write); else passed++;
    total++; if (wb_rd !== 5'd0) $display("FAIL reset_rd got %0d exp 0", wb_rd); else passed++;
    total++; if (wb_data !== 64'd0) $display("FAIL reset_data got %h exp 0", wb_data); else passed++;
    total++; if (busy_mask !== 32'd0) $display("FAIL reset_busy got %h exp 0", busy_mask); else passed++;
    total++; if (protocol_err !== 1'b0) $display("FAIL reset_err got %b exp 0", protocol_err); else passed++;
    total++; if (lu_ready !== 1'b1) $display("FAIL reset_lu_ready got %b exp 1", lu_ready); else passed++;
    total++; if (alu_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", alu_stall); else passed++;
    #10 reset_n = 1;
    tick;
  endtask

  task automatic test_alu_write;
    alu_valid = 1; alu_rd = 5; alu_data = 64'hDEAD;
    tick;
    alu_valid = 0;
    total++; if (wb_reg_write !== 1'b1) $display("FAIL alu_wr got %b exp 1", wb_reg_write); else passed++;
    total++; if (wb_rd !== 5'd5) $display("FAIL alu_rd got %0d exp 5", wb_rd); else passed++;
    total++; if (wb_data !== 64'hDEAD) $display("FAIL alu_data got %h exp dead", wb_data); else passed++;
    tick;
    total++; if (wb_reg_write !== 1'b0) $display("FAIL idle_wr got %b exp 0", wb_reg_write); else passed++;
    total++; if (wb_rd !== 5'd5 || wb_data !== 64'hDEAD) $display("FAIL idle_hold got rd %0d data %h exp 5/dead", wb_rd, wb_data); else passed++;
  endtask

  task automatic test_order;
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1; alu_rd = 5'(i); alu_data = 64'hA0 + 64'(i);
      lu_valid = (i == 1); lu_rd = 7; lu_data = 64'h11;
      tick;
      total++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'(i) || wb_data !== 64'hA0 + 64'(i))
        $display("FAIL order_alu%0d got wr %b rd %0d data %h exp 1/%0d/%h", i, wb_reg_write, wb_rd, wb_data, i, 64'hA0 + 64'(i));
      else passed++;
    end
    alu_valid = 0; lu_valid = 0;
    tick;
    total++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 64'h11)
      $display("FAIL order_lu got wr %b rd %0d data %h exp 1/7/11", wb_reg_write, wb_rd, wb_data); else passed++;
    tick;
    total++; if (wb_reg_write !== 1'b0) $display("FAIL order_idle got %b exp 0", wb_reg_write); else passed++;
    // lu acceptance to writeback is two edges
    lu_valid = 1; lu_rd = 8; lu_data = 64'h88;
    tick;
    lu_valid = 0;
    total++; if (wb_reg_write !== 1'b0) $display("FAIL lu_lat1 got %b exp 0", wb_reg_write); else passed++;
    tick;
    total++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 64'h88)
      $display("FAIL lu_lat2 got wr %b rd %0d data %h exp 1/8/88", wb_reg_write, wb_rd, wb_data); else passed++;
  endtask

  task automatic test_full_protocol;
    for (int i = 0; i < 4; i++) begin
      total++; if (lu_ready !== 1'b1) $display("FAIL fill_ready%0d got %b exp 1", i, lu_ready); else passed++;
      alu_valid = 1; alu_rd = 4; alu_data = 64'h40 + 64'(i);
      lu_valid = 1; lu_rd = 5'(10 + i); lu_data = 64'h100 + 64'(i);
      tick;
    end
    lu_valid = 0; alu_valid = 0;
    total++; if (lu_ready !== 1'b0 || alu_stall !== 1'b1) $display("FAIL full_flags got ready %b stall %b exp 0/1", lu_ready, alu_stall); else passed++;
    total++; if (protocol_err !== 1'b0) $display("FAIL err_early got %b exp 0", protocol_err); else passed++;
    total++; if (wb_rd !== 5'd4 || wb_data !== 64'h43) $display("FAIL fill_alu got rd %0d data %h exp 4/43", wb_rd, wb_data); else passed++;
    alu_valid = 1; alu_rd = 6; alu_data = 64'h66;
    tick;
    alu_valid = 0;
    total++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'd6) $display("FAIL stall_alu got wr %b rd %0d exp 1/6", wb_reg_write, wb_rd); else passed++;
    total++; if (protocol_err !== 1'b1) $display("FAIL err_set got %b exp 1", protocol_err); else passed++;
    total++; if (alu_stall !== 1'b1) $display("FAIL still_full got %b exp 1", alu_stall); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'(10 + i) || wb_data !== 64'h100 + 64'(i))
        $display("FAIL drain%0d got wr %b rd %0d data %h exp 1/%0d/%h", i, wb_reg_write, wb_rd, wb_data, 10 + i, 64'h100 + 64'(i));
      else passed++;
    end
    tick;
    total++; if (wb_reg_write !== 1'b0 || alu_stall !== 1'b0 || lu_ready !== 1'b1)
      $display("FAIL drained got wr %b stall %b ready %b exp 0/0/1", wb_reg_write, alu_stall, lu_ready); else passed++;
    total++; if (protocol_err !== 1'b1) $display("FAIL err_sticky got %b exp 1", protocol_err); else passed++;
    #2 reset_n = 0;
    #1;
    total++; if (protocol_err !== 1'b0) $display("FAIL err_clear got %b exp 0", protocol_err); else passed++;
    reset_n = 1;
    tick;
  endtask

  task automatic test_rd0;
    alu_valid = 1; alu_rd = 0; alu_data = 64'h5;
    tick;
    total++; if (wb_reg_write !== 1'b0) $display("FAIL alu_rd0 got %b exp 0", wb_reg_write); else passed++;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 3; alu_data = 64'h33;
      lu_valid = 1; lu_rd = (i == 0) ? 5'd0 : 5'(19 + i); lu_data = 64'h200 + 64'(i);
      tick;
    end
    alu_valid = 0; lu_valid = 0;
    total++; if (alu_stall !== 1'b1) $display("FAIL rd0_full got %b exp 1", alu_stall); else passed++;
    tick;
    total++; if (wb_reg_write !== 1'b0) $display("FAIL lu_rd0 got %b exp 0", wb_reg_write); else passed++;
    total++; if (alu_stall !== 1'b0) $display("FAIL rd0_popped got %b exp 0", alu_stall); else passed++;
    total++; if (busy_mask[0] !== 1'b0) $display("FAIL busy0 got %b exp 0", busy_mask[0]); else passed++;
    for (int i = 1; i < 4; i++) begin
      tick;
      total++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'(19 + i))
        $display("FAIL rd0_drain%0d got wr %b rd %0d exp 1/%0d", i, wb_reg_write, wb_rd, 19 + i); else passed++;
    end
  endtask

  task automatic test_scoreboard;
`ifdef REGFILE_WB_SCOREBOARD_EN
    issue_valid = 1; issue_rd = 9;
    tick;
    issue_valid = 0;
    total++; if (busy_mask !== 32'h200) $display("FAIL sb_set got %h exp 200", busy_mask); else passed++;
    lu_valid = 1; lu_rd = 9; lu_data = 64'h99;
    tick;
    lu_valid = 0;
    total++; if (busy_mask !== 32'h200) $display("FAIL sb_pushed got %h exp 200", busy_mask); else passed++;
    tick;
    total++; if (wb_rd !== 5'd9 || busy_mask !== 32'h0) $display("FAIL sb_clear got rd %0d busy %h exp 9/0", wb_rd, busy_mask); else passed++;
    issue_valid = 1; issue_rd = 9;
    tick;
    issue_valid = 0; lu_valid = 1; lu_rd = 9; lu_data = 64'h9A;
    tick;
    lu_valid = 0; issue_valid = 1; issue_rd = 9;
    tick;
    issue_valid = 0;
    total++; if (wb_rd !== 5'd9 || wb_data !== 64'h9A || busy_mask !== 32'h200)
      $display("FAIL sb_setwins got rd %0d data %h busy %h exp 9/9a/200", wb_rd, wb_data, busy_mask); else passed++;
    issue_valid = 1; issue_rd = 0;
    tick;
    issue_valid = 0;
    total++; if (busy_mask !== 32'h200) $display("FAIL sb_rd0 got %h exp 200", busy_mask); else passed++;
`else
    issue_valid = 1; issue_rd = 9;
    tick;
    issue_valid = 0;
    total++; if (busy_mask !== 32'h0) $display("FAIL sb_off got %h exp 0", busy_mask); else passed++;
`endif
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 2; alu_data = 64'h22;
      lu_valid = 1; lu_rd = 5'(14 + i); lu_data = 64'h300 + 64'(i);
      tick;
    end
    idle_inputs;
    #2 reset_n = 0;
    #1;
    total++; if (wb_reg_write !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 64'd0)
      $display("FAIL mid_wb got wr %b rd %0d data %h exp 0/0/0", wb_reg_write, wb_rd, wb_data); else passed++;
    total++; if (lu_ready !== 1'b1 || alu_stall !== 1'b0 || busy_mask !== 32'd0 || protocol_err !== 1'b0)
      $display("FAIL mid_flags got ready %b stall %b busy %h err %b exp 1/0/0/0", lu_ready, alu_stall, busy_mask, protocol_err); else passed++;
    tick; tick;
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++; if (wb_reg_write !== 1'b0) $display("FAIL stale%0d got %b exp 0", i, wb_reg_write); else passed++;
    end
  endtask

  initial begin
    reset_n = 0;
    idle_inputs;
    test_reset;
    test_alu_write;
    test_order;
    test_full_protocol;
    test_rd0;
    test_scoreboard;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
